// File: rtl/rvm_axi4_sram_slave.sv
// AXI4 single-beat slave in front of one synchronous single-port SRAM.
// One outstanding transaction; writes win ties against reads in IDLE.
module rvm_axi4_sram_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 65536,
    parameter int unsigned SRAM_AW   = 14
) (
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic [31:0]        S_AXI_ARADDR,
    input  logic [2:0]         S_AXI_ARSIZE,
    input  logic               S_AXI_ARVALID,
    output logic               S_AXI_ARREADY,
    input  logic [31:0]        S_AXI_AWADDR,
    input  logic [2:0]         S_AXI_AWSIZE,
    input  logic               S_AXI_AWVALID,
    output logic               S_AXI_AWREADY,
    input  logic [31:0]        S_AXI_WDATA,
    input  logic [3:0]         S_AXI_WSTRB,
    input  logic               S_AXI_WVALID,
    output logic               S_AXI_WREADY,
    output logic [1:0]         S_AXI_BRESP,
    output logic               S_AXI_BVALID,
    input  logic               S_AXI_BREADY,
    output logic [31:0]        S_AXI_RDATA,
    output logic [1:0]         S_AXI_RRESP,
    output logic               S_AXI_RVALID,
    input  logic               S_AXI_RREADY,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [31:0]        sram_wdata,
    output logic [3:0]         sram_ben,
    output logic               sram_cen,
    output logic               sram_wen,
    input  logic [31:0]        sram_rdata
);

    localparam int unsigned   MAX_SIZE    = 2;
    localparam logic [31:0]   MEM_LIMIT   = 32'(MEM_BYTES);
    localparam logic [1:0]    RESP_OKAY   = 2'b00;
    localparam logic [1:0]    RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, WR_MEM, WR_RESP, RD_MEM, RD_CAP, RD_RESP
    } state_t;

    state_t      state;
    logic [31:0] aw_addr_q;
    logic [2:0]  aw_size_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic        err_q;

    logic        aw_hs, w_hs, ar_hs, wr_go_c;
    logic [31:0] wr_addr_c, wr_data_c, wr_off_c, rd_off_c;
    logic [2:0]  wr_size_c;
    logic [3:0]  wr_strb_c;
    logic        wr_err_c, rd_err_c;

    // Ready decode: reads only start from IDLE when no write is being offered.
    assign S_AXI_AWREADY = !ARESET && (state == IDLE || state == WR_ADDR);
    assign S_AXI_WREADY  = !ARESET && (state == IDLE || state == WR_DATA);
    assign S_AXI_ARREADY = !ARESET && (state == IDLE) && !S_AXI_AWVALID && !S_AXI_WVALID;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // Merge the beat arriving this cycle with whichever half was latched earlier.
    always_comb begin
        wr_addr_c = aw_hs ? S_AXI_AWADDR : aw_addr_q;
        wr_size_c = aw_hs ? S_AXI_AWSIZE : aw_size_q;
        wr_data_c = w_hs  ? S_AXI_WDATA  : w_data_q;
        wr_strb_c = w_hs  ? S_AXI_WSTRB  : w_strb_q;
        wr_off_c  = wr_addr_c - BASE_ADDR;
        rd_off_c  = S_AXI_ARADDR - BASE_ADDR;
        wr_err_c  = (wr_off_c >= MEM_LIMIT) || (32'(wr_size_c) > 32'(MAX_SIZE));
        rd_err_c  = (rd_off_c >= MEM_LIMIT) || (32'(S_AXI_ARSIZE) > 32'(MAX_SIZE));
        wr_go_c   = ((state == IDLE) && aw_hs && w_hs) ||
                    ((state == WR_DATA) && w_hs) ||
                    ((state == WR_ADDR) && aw_hs);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state        <= IDLE;
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= 2'b00;
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA  <= '0;
            S_AXI_RRESP  <= 2'b00;
            sram_addr    <= '0;
            sram_wdata   <= '0;
            sram_ben     <= '0;
            sram_cen     <= 1'b0;
            sram_wen     <= 1'b0;
            err_q        <= 1'b0;
            aw_addr_q    <= '0;
            aw_size_q    <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
        end else begin
            if (aw_hs) begin
                aw_addr_q <= S_AXI_AWADDR;
                aw_size_q <= S_AXI_AWSIZE;
            end
            if (w_hs) begin
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end

            // SRAM strobe is a single-cycle pulse, suppressed for erroring requests.
            if (wr_go_c) begin
                sram_addr  <= wr_off_c[SRAM_AW+1:2];
                sram_wdata <= wr_data_c;
                sram_ben   <= wr_strb_c;
                sram_cen   <= !wr_err_c;
                sram_wen   <= !wr_err_c;
                err_q      <= wr_err_c;
            end else if (ar_hs) begin
                sram_addr  <= rd_off_c[SRAM_AW+1:2];
                sram_cen   <= !rd_err_c;
                sram_wen   <= 1'b0;
                err_q      <= rd_err_c;
            end else begin
                sram_cen   <= 1'b0;
                sram_wen   <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (aw_hs && w_hs) state <= WR_MEM;
                    else if (aw_hs)    state <= WR_DATA;
                    else if (w_hs)     state <= WR_ADDR;
                    else if (ar_hs)    state <= RD_MEM;
                end
                WR_DATA: if (w_hs)  state <= WR_MEM;
                WR_ADDR: if (aw_hs) state <= WR_MEM;
                WR_MEM: begin
                    S_AXI_BVALID <= 1'b1;
                    S_AXI_BRESP  <= err_q ? RESP_SLVERR : RESP_OKAY;
                    state        <= WR_RESP;
                end
                WR_RESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID <= 1'b0;
                        state        <= IDLE;
                    end
                end
                RD_MEM: state <= RD_CAP;
                RD_CAP: begin
                    S_AXI_RDATA  <= err_q ? 32'h0 : sram_rdata;
                    S_AXI_RRESP  <= err_q ? RESP_SLVERR : RESP_OKAY;
                    S_AXI_RVALID <= 1'b1;
                    state        <= RD_RESP;
                end
                RD_RESP: begin
                    if (S_AXI_RREADY) begin
                        S_AXI_RVALID <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rvm_axi4_sram_slave.sv
// Bench for rvm_axi4_sram_slave: directed scenarios plus random traffic,
// checked against a word-array memory model and a per-cycle response monitor.
module tb_rvm_axi4_sram_slave;

    localparam logic [31:0] BASE  = 32'h2000_0000;
    localparam int unsigned MEMB  = 4096;
    localparam int unsigned AW    = 10;
    localparam int unsigned WORDS = MEMB / 4;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic [31:0]   S_AXI_ARADDR, S_AXI_AWADDR, S_AXI_WDATA;
    logic [2:0]    S_AXI_ARSIZE, S_AXI_AWSIZE;
    logic          S_AXI_ARVALID, S_AXI_AWVALID, S_AXI_WVALID;
    logic          S_AXI_ARREADY, S_AXI_AWREADY, S_AXI_WREADY;
    logic [3:0]    S_AXI_WSTRB;
    logic [1:0]    S_AXI_BRESP, S_AXI_RRESP;
    logic          S_AXI_BVALID, S_AXI_BREADY, S_AXI_RVALID, S_AXI_RREADY;
    logic [31:0]   S_AXI_RDATA;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata, sram_rdata;
    logic [3:0]    sram_ben;
    logic          sram_cen, sram_wen;

    rvm_axi4_sram_slave #(.BASE_ADDR(BASE), .MEM_BYTES(MEMB), .SRAM_AW(AW)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARSIZE(S_AXI_ARSIZE),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWSIZE(S_AXI_AWSIZE),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_ben(sram_ben),
        .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_rdata(sram_rdata)
    );

    always #5 ACLK = ~ACLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int cen_count = 0;
    int exp_cen   = 0;
    int last_ar_hs_cyc = 0;
    int last_b_hs_cyc  = 0;
    bit rd_pending = 0;
    bit wr_pending = 0;
    logic [31:0] exp_rdata = '0;
    logic [1:0]  exp_rresp = '0;
    logic [1:0]  exp_bresp = '0;
    bit [31:0]   sram_mem [WORDS];
    bit [31:0]   ref_mem  [WORDS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge ACLK) cyc <= cyc + 1;

    // Behavioural SRAM: data appears the cycle after a read strobe, garbage otherwise.
    always @(posedge ACLK) begin
        bit [31:0] w;
        if (sram_cen) cen_count <= cen_count + 1;
        if (sram_cen && sram_wen) begin
            w = sram_mem[int'(sram_addr)];
            for (int b = 0; b < 4; b++)
                if (sram_ben[b]) w[8*b +: 8] = sram_wdata[8*b +: 8];
            sram_mem[int'(sram_addr)] = w;
        end
        sram_rdata <= (sram_cen && !sram_wen) ? sram_mem[int'(sram_addr)] : $urandom;
    end

    function automatic bit model_err(input logic [31:0] addr, input logic [2:0] size);
        logic [31:0] off;
        off = addr - BASE;
        return (off >= 32'(MEMB)) || (size > 3'd2);
    endfunction

    function automatic int model_idx(input logic [31:0] addr);
        return int'((addr - BASE) >> 2);
    endfunction

    // Response monitor: any visible response must match the model's expectation.
    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (S_AXI_RVALID) begin
                if (!rd_pending) check("rvalid_unexpected", 32'(S_AXI_RVALID), 32'd0);
                else begin
                    check("rdata_vs_model", S_AXI_RDATA, exp_rdata);
                    check("rresp_vs_model", 32'(S_AXI_RRESP), 32'(exp_rresp));
                end
            end
            if (S_AXI_BVALID) begin
                if (!wr_pending) check("bvalid_unexpected", 32'(S_AXI_BVALID), 32'd0);
                else check("bresp_vs_model", 32'(S_AXI_BRESP), 32'(exp_bresp));
            end
            if (S_AXI_AWVALID || S_AXI_WVALID)
                check("arready_while_write_offered", 32'(S_AXI_ARREADY), 32'd0);
        end
    end

    task automatic do_write(input logic [31:0] addr, input logic [2:0] size,
                            input logic [31:0] data, input logic [3:0] strb,
                            input int skew, input int bdelay, output logic [1:0] gresp);
        int  aw_start, w_start, last_c, v_c, idx;
        bit  aw_done, w_done, ok, err;
        bit [31:0] w;
        gresp = 2'b11;
        aw_start = (skew > 0) ? skew : 0;
        w_start  = (skew < 0) ? -skew : 0;
        S_AXI_AWADDR = addr; S_AXI_AWSIZE = size;
        S_AXI_WDATA  = data; S_AXI_WSTRB  = strb;
        aw_done = 0; w_done = 0; last_c = 0;
        for (int t = 0; t < 40 && !(aw_done && w_done); t++) begin
            if (!aw_done && t >= aw_start) S_AXI_AWVALID = 1'b1;
            if (!w_done  && t >= w_start)  S_AXI_WVALID  = 1'b1;
            @(negedge ACLK);
            if (S_AXI_AWVALID && S_AXI_AWREADY) begin aw_done = 1; last_c = cyc; end
            if (S_AXI_WVALID  && S_AXI_WREADY)  begin w_done  = 1; last_c = cyc; end
            @(posedge ACLK); #1;
            if (aw_done) S_AXI_AWVALID = 1'b0;
            if (w_done)  S_AXI_WVALID  = 1'b0;
        end
        if (!(aw_done && w_done)) begin
            S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
            check("write_handshake_timeout", 32'd0, 32'd1);
            return;
        end
        err = model_err(addr, size);
        idx = err ? 0 : model_idx(addr);
        exp_bresp = err ? 2'b10 : 2'b00;
        if (!err) begin
            w = ref_mem[idx];
            for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
            ref_mem[idx] = w;
            exp_cen++;
        end
        wr_pending = 1;
        S_AXI_BREADY = (bdelay == 0);
        ok = 0; v_c = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge ACLK);
            if (S_AXI_BVALID) begin ok = 1; v_c = cyc; gresp = S_AXI_BRESP; end
        end
        if (!ok) begin
            check("bvalid_timeout", 32'd0, 32'd1);
            wr_pending = 0; S_AXI_BREADY = 1'b0;
            return;
        end
        check("write_latency", 32'(v_c - last_c), 32'd2);
        if (bdelay > 0) begin
            repeat (bdelay) @(posedge ACLK);
            #1 S_AXI_BREADY = 1'b1;
            @(negedge ACLK);
            check("bvalid_held", 32'(S_AXI_BVALID), 32'd1);
        end
        last_b_hs_cyc = cyc;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0; wr_pending = 0;
        if (!err) check("sram_word_after_write", sram_mem[idx], ref_mem[idx]);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [2:0] size, input int rdelay,
                           output logic [31:0] got, output logic [1:0] gresp);
        bit ok, err;
        int hs_c, v_c;
        got = '0; gresp = 2'b11;
        S_AXI_ARADDR = addr; S_AXI_ARSIZE = size; S_AXI_ARVALID = 1'b1;
        ok = 0; hs_c = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge ACLK);
            if (S_AXI_ARREADY) begin ok = 1; hs_c = cyc; end
            @(posedge ACLK); #1;
        end
        S_AXI_ARVALID = 1'b0;
        if (!ok) begin check("ar_handshake_timeout", 32'd0, 32'd1); return; end
        last_ar_hs_cyc = hs_c;
        err = model_err(addr, size);
        exp_rresp = err ? 2'b10 : 2'b00;
        exp_rdata = err ? 32'h0 : ref_mem[model_idx(addr)];
        if (!err) exp_cen++;
        rd_pending = 1;
        S_AXI_RREADY = (rdelay == 0);
        ok = 0; v_c = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge ACLK);
            if (S_AXI_RVALID) begin ok = 1; v_c = cyc; got = S_AXI_RDATA; gresp = S_AXI_RRESP; end
        end
        if (!ok) begin
            check("rvalid_timeout", 32'd0, 32'd1);
            rd_pending = 0; S_AXI_RREADY = 1'b0;
            return;
        end
        check("read_latency", 32'(v_c - hs_c), 32'd3);
        if (rdelay > 0) begin
            repeat (rdelay) @(posedge ACLK);
            #1 S_AXI_RREADY = 1'b1;
            @(negedge ACLK);
            check("rvalid_held", 32'(S_AXI_RVALID), 32'd1);
        end
        @(posedge ACLK); #1;
        S_AXI_RREADY = 1'b0; rd_pending = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          c0;
        logic [31:0] ra;
        logic [2:0]  rs;

        ARESET = 1'b1;
        S_AXI_ARADDR = '0; S_AXI_ARSIZE = '0; S_AXI_ARVALID = 1'b0;
        S_AXI_AWADDR = '0; S_AXI_AWSIZE = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_arready", 32'(S_AXI_ARREADY), 0);
        check("rst_awready", 32'(S_AXI_AWREADY), 0);
        check("rst_wready",  32'(S_AXI_WREADY), 0);
        check("rst_valids",  32'({S_AXI_BVALID, S_AXI_RVALID}), 0);
        check("rst_rdata",   S_AXI_RDATA, 0);
        check("rst_resps",   32'({S_AXI_RRESP, S_AXI_BRESP}), 0);
        check("rst_sram_ctl", 32'({sram_cen, sram_wen, sram_ben}), 0);
        check("rst_sram_addr", 32'(sram_addr), 0);
        check("rst_sram_wdata", sram_wdata, 0);
        @(posedge ACLK); #1 ARESET = 1'b0;
        @(negedge ACLK);
        check("idle_awready", 32'(S_AXI_AWREADY), 1);
        check("idle_arready", 32'(S_AXI_ARREADY), 1);
        @(posedge ACLK); #1;

        // Basic write then read back
        do_write(BASE + 32'h10, 3'd2, 32'hDEADBEEF, 4'hF, 0, 0, r);
        check("t1_bresp", 32'(r), 0);
        do_read(BASE + 32'h10, 3'd2, 0, d, r);
        check("t1_rdata", d, 32'hDEADBEEF);
        check("t1_rresp", 32'(r), 0);

        // Partial strobe merge
        do_write(BASE + 32'h10, 3'd2, 32'h1111_2222, 4'h3, 0, 0, r);
        do_read(BASE + 32'h10, 3'd2, 0, d, r);
        check("t2_rdata", d, 32'hDEAD2222);

        // W ahead of AW, then AW ahead of W: exactly one SRAM write each
        c0 = cen_count;
        do_write(BASE + 32'h20, 3'd2, 32'hA5A5_0001, 4'hF, 2, 0, r);
        check("t3_w_first_bresp", 32'(r), 0);
        check("t3_w_first_cen", 32'(cen_count - c0), 1);
        c0 = cen_count;
        do_write(BASE + 32'h24, 3'd2, 32'h5A5A_0002, 4'hF, -2, 0, r);
        check("t3_aw_first_bresp", 32'(r), 0);
        check("t3_aw_first_cen", 32'(cen_count - c0), 1);
        do_read(BASE + 32'h20, 3'd2, 0, d, r);
        check("t3_rdata0", d, 32'hA5A5_0001);
        do_read(BASE + 32'h24, 3'd2, 0, d, r);
        check("t3_rdata1", d, 32'h5A5A_0002);

        // Simultaneous AR and AW: write first, read after B handshake
        fork
            begin
                logic [1:0] wr_r;
                do_write(BASE + 32'h30, 3'd2, 32'hCAFE_F00D, 4'hF, 0, 0, wr_r);
            end
            do_read(BASE + 32'h30, 3'd2, 0, d, r);
        join
        check("t4_read_after_b", 32'(last_ar_hs_cyc > last_b_hs_cyc), 1);
        check("t4_rdata", d, 32'hCAFE_F00D);

        // Error cases: no SRAM strobe, SLVERR, zero data
        c0 = cen_count;
        do_read(BASE + 32'(MEMB) + 32'd4, 3'd2, 0, d, r);
        check("t5_oob_rdata", d, 0);
        check("t5_oob_rresp", 32'(r), 32'h2);
        do_write(BASE + 32'h40, 3'b011, 32'h1234_5678, 4'hF, 0, 0, r);
        check("t5_size_bresp", 32'(r), 32'h2);
        do_read(BASE - 32'd4, 3'd2, 0, d, r);
        check("t5_below_base_rresp", 32'(r), 32'h2);
        check("t5_no_cen", 32'(cen_count - c0), 0);
        do_read(BASE + 32'h40, 3'd2, 0, d, r);
        check("t5_untouched", d, 0);

        // Backpressure on both response channels
        do_write(BASE + 32'h50, 3'd2, 32'h0BAD_F00D, 4'hF, 0, 5, r);
        check("t6_bresp", 32'(r), 0);
        do_read(BASE + 32'h50, 3'd2, 5, d, r);
        check("t6_rdata", d, 32'h0BAD_F00D);

        // Reset landing in the capture cycle drops the read
        S_AXI_ARADDR = BASE + 32'h50; S_AXI_ARSIZE = 3'd2; S_AXI_ARVALID = 1'b1;
        @(negedge ACLK);
        check("t6_ar_ready", 32'(S_AXI_ARREADY), 1);
        @(posedge ACLK); #1 S_AXI_ARVALID = 1'b0;
        exp_cen++;
        @(posedge ACLK); #1 ARESET = 1'b1;
        @(posedge ACLK); #1;
        check("t6_rst_rvalid", 32'(S_AXI_RVALID), 0);
        check("t6_rst_arready", 32'(S_AXI_ARREADY), 0);
        ARESET = 1'b0;
        @(negedge ACLK);
        check("t6_idle_after_rst", 32'(S_AXI_ARREADY), 1);
        repeat (4) begin
            @(negedge ACLK);
            check("t6_no_late_rvalid", 32'(S_AXI_RVALID), 0);
        end
        @(posedge ACLK); #1;
        check("t6_cen_count", 32'(cen_count), 32'(exp_cen));

        // Random traffic against the model
        for (int n = 0; n < 120; n++) begin
            case ($urandom % 8)
                0:       ra = BASE + 32'(MEMB) + 32'($urandom % 64);
                1:       ra = BASE - 32'd1 - 32'($urandom % 16);
                default: ra = BASE + 32'(($urandom % 16) * 4) + 32'($urandom % 4);
            endcase
            rs = (($urandom % 8) == 0) ? 3'($urandom % 8) : 3'd2;
            if ($urandom % 2) begin
                do_write(ra, rs, $urandom, 4'($urandom), int'($urandom_range(0, 4)) - 2,
                         int'($urandom_range(0, 3)), r);
            end else begin
                do_read(ra, rs, int'($urandom_range(0, 3)), d, r);
            end
            check("rand_cen_count", 32'(cen_count), 32'(exp_cen));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
